pe_row_feeder: RTL and testbench
================================

// Module: pe_row_feeder
// PURPOSE
//  Transmit side of the PE operand interface (fire + 8-bit operand per lane). Buffers operand
//  vectors from the loader and launches them into the N rows of the systolic array as a skewed
//  wavefront: lane i lags lane 0 by i cycles. Sequences one tile of LEN beats, then flushes the skew.
// PARAMETERS
//  N          4    lanes (array rows) driven
//  DATA_W     8    operand width per lane
//  FIFO_DEPTH 8    input vector buffer entries (power of 2)
//  LEN_W      16   width of beat-count input
// PORTS
//  clk        in   1         clock, all logic on posedge
//  rst        in   1         synchronous reset, active-high
//  start      in   1         begin tile; sampled only in IDLE
//  len        in   LEN_W     beats in tile; sampled with start
//  busy       out  1         high in STREAM/FLUSH/DONE
//  done       out  1         one-cycle pulse at end of tile
//  in_valid   in   1         loader vector valid
//  in_ready   out  1         buffer can accept (= !full, 0 while rst)
//  in_data    in   N*DATA_W  lane i at [i*DATA_W +: DATA_W]
//  out_fire   out  N         per-lane operand valid to PE row i
//  out_data   out  N*DATA_W  per-lane operand; forced 0 when out_fire[i]=0
//  stall_cnt  out  16        underflow bubble count (only with PE_FEEDER_STALL_CNT_EN)
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, busy=0, done=0, out_fire=0, out_data=0, stall_cnt=0, in_ready=0.
//    Reset mid-tile discards buffered and in-flight beats in one cycle; no done pulse.
//  - FIFO: push on in_valid&&in_ready in any state. No fall-through: word pushed at t poppable at t+1.
//    Push and pop same cycle legal when not full; count unchanged. Pointers wrap mod FIFO_DEPTH.
//  - FSM IDLE->STREAM on start (len>0); IDLE->DONE on start with len==0 (no fire emitted).
//    STREAM: each cycle, pop if FIFO non-empty and launch beat; if empty, launch bubble (fire=0),
//    beat counter holds. After beat len-1 is popped -> FLUSH.
//    FLUSH: N-1 cycles launching bubbles so lane N-1 drains; then DONE.
//    DONE: done=1 for exactly one cycle -> IDLE. start outside IDLE ignored.
//  - Latency: beat popped at cycle t appears on lane i at cycle t+1+i (lane 0 registered once).
//    Bubbles travel the same skew, so lane alignment is preserved across stalls.
//  - done asserts the cycle after lane N-1 carries the final beat; busy drops with done.
//  - Data is passed unmodified; no arithmetic on operands. Beat counter LEN_W bits, no wrap (len<2^LEN_W).
// CONFIGURATION
//  PE_FEEDER_STALL_CNT_EN defined: stall_cnt increments on each STREAM bubble, saturates at 16'hFFFF,
//    clears on rst and on accepted start. Undefined: port absent, no counter logic.
// STRUCTURE
//  systola_pkg: DATA_W default, feeder_state_t enum {IDLE, STREAM, FLUSH, DONE}, lane slice helper.
//  One sub-module: pe_skew_line (parameter DELAY; fire+data shift register of DELAY stages,
//  sync reset to 0), instantiated per lane i with DELAY=i. FIFO and FSM inline.
// TESTING (N=4, FIFO_DEPTH=8)
//  - Reset: hold rst 3 cycles mid-tile -> all outputs 0, in_ready 0; after release in_ready=1, state IDLE.
//  - Tile len=3, vectors 0x04030201,0x08070605,0x0C0B0A09 preloaded, start -> lane0 fires 01,05,09 at
//    t+1..t+3; lane3 fires 04,08,0C at t+4..t+6; done pulse at t+7; busy low after.
//  - Underflow: len=2, push vector1, start, push vector2 3 cycles later -> bubble on every lane at the
//    same relative slot; skew intact; stall_cnt=2 with macro on.
//  - Full FIFO: push 8 vectors with no start -> in_ready=0 after 8th; 9th held by loader, accepted
//    after first pop; no loss, order preserved.
//  - len=0 start -> done pulse next-but-one cycle, out_fire stays 0; start during STREAM ignored.
//  - Back-to-back tiles: start asserted the cycle after done -> second tile accepted, outputs correct.

Source files
------------

// File: rtl/systola_pkg.sv
// Shared types and helpers for the systolic-array operand feeder.
package systola_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  // Bit offset of lane 'lane' inside a packed multi-lane vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pe_skew_line.sv
// Fire + operand delay line of DELAY stages, used to skew one lane of the wavefront.
module pe_skew_line
  import systola_pkg::*;
#(
  parameter int DELAY  = 0,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_fire,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_fire,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (DELAY == 0) begin : g_pass
      // Lane 0 is already registered by the launch stage; no extra delay.
      logic unused_ctl;
      assign unused_ctl = clk | rst;
      assign out_fire   = in_fire;
      assign out_data   = in_data;
    end else begin : g_shift
      logic [DELAY-1:0]             fire_sr;
      logic [DELAY-1:0][DATA_W-1:0] data_sr;

      // Shift fire and data together so bubbles keep their slot in the skew.
      always_ff @(posedge clk) begin
        if (rst) begin
          fire_sr <= '0;
          data_sr <= '0;
        end else begin
          fire_sr[0] <= in_fire;
          data_sr[0] <= in_data;
          for (int s = 1; s < DELAY; s++) begin
            fire_sr[s] <= fire_sr[s-1];
            data_sr[s] <= data_sr[s-1];
          end
        end
      end

      assign out_fire = fire_sr[DELAY-1];
      assign out_data = data_sr[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/pe_row_feeder.sv
// Operand feeder for the N rows of the systolic array: buffers loader vectors and launches
// one tile as a skewed wavefront (lane i lags lane 0 by i cycles), then flushes the skew.
// Optional build macro PE_FEEDER_STALL_CNT_EN adds the stall_cnt underflow bubble counter.
//
//  state  | meaning
//  IDLE   | waiting for start; len sampled with start
//  STREAM | pop one vector per cycle when available, otherwise launch a bubble
//  FLUSH  | N-1 bubble cycles so the last beat drains out of lane N-1
//  DONE   | tile finished; done pulses on the following cycle
module pe_row_feeder
  import systola_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic [N-1:0]        out_fire,
  output logic [N*DATA_W-1:0] out_data
`ifdef PE_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FLUSH_CYC = N - 1;
  localparam int FL_W      = (N > 2) ? $clog2(N) : 1;

  // ---------------- input vector buffer ----------------
  logic [N*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;

  // Storage array; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- tile sequencer ----------------
  feeder_state_t    state;
  feeder_state_t    state_nxt;
  logic [LEN_W-1:0] beats_left;
  logic [LEN_W-1:0] beats_left_nxt;
  logic [FL_W-1:0]  flush_cnt;
  logic [FL_W-1:0]  flush_cnt_nxt;
  logic             done_q;

  // State, beat down-counter and flush down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beats_left <= '0;
      flush_cnt  <= '0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
      flush_cnt  <= flush_cnt_nxt;
      done_q     <= (state == DONE);
    end
  end

  // Next-state decode; a pop happens only in STREAM with a vector available.
  always_comb begin
    state_nxt      = state;
    beats_left_nxt = beats_left;
    flush_cnt_nxt  = flush_cnt;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt      = STREAM;
            beats_left_nxt = len;
          end
        end
      end
      STREAM: begin
        if (!empty) begin
          pop            = 1'b1;
          beats_left_nxt = beats_left - LEN_W'(1);
          if (beats_left == LEN_W'(1)) begin
            if (FLUSH_CYC == 0) begin
              state_nxt = DONE;
            end else begin
              state_nxt     = FLUSH;
              flush_cnt_nxt = FL_W'(FLUSH_CYC - 1);
            end
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_nxt = DONE;
        end else begin
          flush_cnt_nxt = flush_cnt - FL_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = done_q;

  // ---------------- launch stage and lane skew ----------------
  logic                launch_fire;
  logic [N*DATA_W-1:0] launch_data;

  // Common launch register: every lane sees the same beat or bubble, then skews.
  always_ff @(posedge clk) begin
    if (rst) begin
      launch_fire <= 1'b0;
      launch_data <= '0;
    end else begin
      launch_fire <= pop;
      launch_data <= pop ? fifo_mem[rd_ptr] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic              lane_fire;
    logic [DATA_W-1:0] lane_data;

    pe_skew_line #(
      .DELAY  (i),
      .DATA_W (DATA_W)
    ) u_skew (
      .clk      (clk),
      .rst      (rst),
      .in_fire  (launch_fire),
      .in_data  (launch_data[lane_lsb(i, DATA_W) +: DATA_W]),
      .out_fire (lane_fire),
      .out_data (lane_data)
    );

    assign out_fire[i]                                 = lane_fire;
    assign out_data[lane_lsb(i, DATA_W) +: DATA_W] = lane_fire ? lane_data : '0;
  end

`ifdef PE_FEEDER_STALL_CNT_EN
  logic stall_inc;
  logic start_acc;

  assign stall_inc = (state == STREAM) && empty;
  assign start_acc = (state == IDLE) && start;

  // Saturating count of STREAM bubbles, cleared when a new tile is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed self-checking bench for pe_row_feeder (N=4, FIFO_DEPTH=8).
module tb_pe_row_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LW-1:0]   len;
  logic            busy;
  logic            done;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    out_fire;
  logic [N*DW-1:0] out_data;
`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Launch schedule of the current tile: vector index per STREAM cycle, -1 = bubble.
  int              sched[$];
  logic [N*DW-1:0] vecs[$];

  // Loader and mid-tile start stimulus applied during capture.
  logic [N*DW-1:0] ld_q[$];
  int              ld_from     = 0;
  int              mid_start_k = -1;

  logic [N-1:0]    cap_fire [64];
  logic [N*DW-1:0] cap_data [64];
  logic            cap_done [64];
  logic            cap_busy [64];

  always #5 clk = ~clk;

  pe_row_feeder #(
    .N          (N),
    .DATA_W     (DW),
    .FIFO_DEPTH (8),
    .LEN_W      (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_fire  (out_fire),
    .out_data  (out_data)
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [N*DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic kick(input int l);
    start = 1'b1;
    len   = LW'(l);
    step();
    start = 1'b0;
  endtask

  // Records outputs from the first STREAM cycle (k=0) onward while driving the loader.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      logic acc;
      cap_fire[k] = out_fire;
      cap_data[k] = out_data;
      cap_done[k] = done;
      cap_busy[k] = busy;
      if (k == mid_start_k) begin
        start = 1'b1;
        len   = '0;
      end else begin
        start = 1'b0;
      end
      acc = 1'b0;
      if (k >= ld_from && ld_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = ld_q[0];
        acc      = in_ready;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (acc) void'(ld_q.pop_front());
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  function automatic logic [N-1:0] exp_fire(input int k);
    logic [N-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = k - 1 - i;
      if (j >= 0 && j < sched.size()) begin
        if (sched[j] >= 0) f[i] = 1'b1;
      end
    end
    return f;
  endfunction

  function automatic logic [N*DW-1:0] exp_data(input int k);
    logic [N*DW-1:0] d;
    logic [N*DW-1:0] v;
    d = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = k - 1 - i;
      if (j >= 0 && j < sched.size()) begin
        if (sched[j] >= 0) begin
          v = vecs[sched[j]];
          d[i*DW +: DW] = v[i*DW +: DW];
        end
      end
    end
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL por_in_ready got %b exp 0", in_ready); else n_pass++;
    n_total++;
    if ({busy, done, out_fire, out_data} !== '0)
      $display("FAIL por_outputs got busy=%b done=%b fire=%b data=%h exp all 0", busy, done, out_fire, out_data);
    else n_pass++;
    rst = 1'b0;
    step();
    // Start a tile, then reset while beats are in flight.
    push_vec(32'h11111111);
    push_vec(32'h22222222);
    kick(4);
    step();
    step();
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if ({busy, done, out_fire, out_data} !== '0)
        $display("FAIL rst_outputs c=%0d got busy=%b done=%b fire=%b data=%h exp all 0", c, busy, done, out_fire, out_data);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL rst_in_ready c=%0d got %b exp 0", c, in_ready); else n_pass++;
    end
`ifdef PE_FEEDER_STALL_CNT_EN
    n_total++;
    if (stall_cnt !== 16'd0) $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
`endif
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %b exp 1", in_ready); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      step();
      n_total++;
      if ({busy, done, out_fire} !== '0)
        $display("FAIL rel_idle c=%0d got busy=%b done=%b fire=%b exp 0", c, busy, done, out_fire);
      else n_pass++;
    end
  endtask

  task automatic test_tile();
    int ls;
    vecs = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    sched = '{0, 1, 2};
    ls = 3;
    foreach (vecs[v]) push_vec(vecs[v]);
    kick(3);
    capture(ls + 6);
    for (int k = 0; k < ls + 6; k++) begin
      n_total++;
      if (cap_fire[k] !== exp_fire(k)) $display("FAIL tile_fire k=%0d got %b exp %b", k, cap_fire[k], exp_fire(k)); else n_pass++;
      n_total++;
      if (cap_data[k] !== exp_data(k)) $display("FAIL tile_data k=%0d got %h exp %h", k, cap_data[k], exp_data(k)); else n_pass++;
      n_total++;
      if (cap_done[k] !== (k == ls + 4)) $display("FAIL tile_done k=%0d got %b exp %b", k, cap_done[k], (k == ls + 4)); else n_pass++;
      n_total++;
      if (cap_busy[k] !== (k < ls + 4)) $display("FAIL tile_busy k=%0d got %b exp %b", k, cap_busy[k], (k < ls + 4)); else n_pass++;
    end
    n_total++;
    if (cap_data[4][31:24] !== 8'h04) $display("FAIL tile_lane3_first got %h exp 04", cap_data[4][31:24]); else n_pass++;
    n_total++;
    if (cap_data[6][31:24] !== 8'h0C) $display("FAIL tile_lane3_last got %h exp 0c", cap_data[6][31:24]); else n_pass++;
`ifdef PE_FEEDER_STALL_CNT_EN
    n_total++;
    if (stall_cnt !== 16'd0) $display("FAIL tile_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
`endif
  endtask

  task automatic test_underflow();
    int ls;
    vecs = '{32'hA3A2A1A0, 32'hB3B2B1B0};
    sched = '{0, -1, -1, 1};
    ls = 4;
    // Vector 1 pushed with start; vector 2 arrives three cycles later.
    in_valid = 1'b1;
    in_data  = vecs[0];
    kick(2);
    in_valid = 1'b0;
    ld_q     = '{vecs[1]};
    ld_from  = 2;
    capture(ls + 6);
    ld_from  = 0;
    for (int k = 0; k < ls + 6; k++) begin
      n_total++;
      if (cap_fire[k] !== exp_fire(k)) $display("FAIL uf_fire k=%0d got %b exp %b", k, cap_fire[k], exp_fire(k)); else n_pass++;
      n_total++;
      if (cap_data[k] !== exp_data(k)) $display("FAIL uf_data k=%0d got %h exp %h", k, cap_data[k], exp_data(k)); else n_pass++;
      n_total++;
      if (cap_done[k] !== (k == ls + 4)) $display("FAIL uf_done k=%0d got %b exp %b", k, cap_done[k], (k == ls + 4)); else n_pass++;
    end
`ifdef PE_FEEDER_STALL_CNT_EN
    n_total++;
    if (stall_cnt !== 16'd2) $display("FAIL uf_stall_cnt got %0d exp 2", stall_cnt); else n_pass++;
`endif
  endtask

  task automatic test_full_fifo();
    int ls;
    vecs = '{};
    for (int v = 0; v < 9; v++) vecs.push_back({4{8'(8'h30 + v)}} ^ 32'h00010203);
    sched = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    ls = 9;
    for (int v = 0; v < 8; v++) push_vec(vecs[v]);
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else n_pass++;
    // Loader holds the ninth vector while the buffer is full.
    in_valid = 1'b1;
    in_data  = vecs[8];
    step();
    step();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL full_hold_ready got %b exp 0", in_ready); else n_pass++;
    kick(9);
    ld_q        = '{vecs[8]};
    ld_from     = 0;
    mid_start_k = 3;
    capture(ls + 6);
    mid_start_k = -1;
    n_total++;
    if (ld_q.size() !== 0) $display("FAIL full_ninth_accepted got pending=%0d exp 0", ld_q.size()); else n_pass++;
    for (int k = 0; k < ls + 6; k++) begin
      n_total++;
      if (cap_fire[k] !== exp_fire(k)) $display("FAIL full_fire k=%0d got %b exp %b", k, cap_fire[k], exp_fire(k)); else n_pass++;
      n_total++;
      if (cap_data[k] !== exp_data(k)) $display("FAIL full_data k=%0d got %h exp %h", k, cap_data[k], exp_data(k)); else n_pass++;
      n_total++;
      if (cap_done[k] !== (k == ls + 4)) $display("FAIL full_done k=%0d got %b exp %b", k, cap_done[k], (k == ls + 4)); else n_pass++;
    end
`ifdef PE_FEEDER_STALL_CNT_EN
    n_total++;
    if (stall_cnt !== 16'd0) $display("FAIL full_stall_clear got %0d exp 0", stall_cnt); else n_pass++;
`endif
  endtask

  task automatic test_len_zero();
    kick(0);
    n_total++;
    if ({done, busy} !== 2'b01) $display("FAIL len0_c1 got done=%b busy=%b exp done=0 busy=1", done, busy); else n_pass++;
    step();
    n_total++;
    if ({done, busy} !== 2'b10) $display("FAIL len0_c2 got done=%b busy=%b exp done=1 busy=0", done, busy); else n_pass++;
    n_total++;
    if (out_fire !== '0) $display("FAIL len0_fire got %b exp 0000", out_fire); else n_pass++;
    step();
    n_total++;
    if ({done, busy, out_fire} !== '0) $display("FAIL len0_c3 got done=%b busy=%b fire=%b exp 0", done, busy, out_fire); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N*DW-1:0] all_v[$];
    all_v = '{32'hD3D2D1D0, 32'hE3E2E1E0, 32'h13121110, 32'h23222120, 32'h33323130};
    foreach (all_v[v]) push_vec(all_v[v]);
    vecs  = '{all_v[0], all_v[1]};
    sched = '{0, 1};
    kick(2);
    capture(7);
    for (int k = 0; k < 7; k++) begin
      n_total++;
      if (cap_data[k] !== exp_data(k)) $display("FAIL b2b1_data k=%0d got %h exp %h", k, cap_data[k], exp_data(k)); else n_pass++;
      n_total++;
      if (cap_done[k] !== (k == 6)) $display("FAIL b2b1_done k=%0d got %b exp %b", k, cap_done[k], (k == 6)); else n_pass++;
    end
    // Second tile starts the cycle right after the done pulse.
    vecs  = '{all_v[2], all_v[3], all_v[4]};
    sched = '{0, 1, 2};
    kick(3);
    capture(9);
    for (int k = 0; k < 9; k++) begin
      n_total++;
      if (cap_fire[k] !== exp_fire(k)) $display("FAIL b2b2_fire k=%0d got %b exp %b", k, cap_fire[k], exp_fire(k)); else n_pass++;
      n_total++;
      if (cap_data[k] !== exp_data(k)) $display("FAIL b2b2_data k=%0d got %h exp %h", k, cap_data[k], exp_data(k)); else n_pass++;
      n_total++;
      if (cap_done[k] !== (k == 7)) $display("FAIL b2b2_done k=%0d got %b exp %b", k, cap_done[k], (k == 7)); else n_pass++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_tile();
    test_underflow();
    test_full_fifo();
    test_len_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
